// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg -- constants and types shared by the UART transmitter and receiver.
//   BAUD_DIV_DEFAULT : clocks per bit, 50 MHz / 19200 baud
//   half_bit()       : mid-bit offset used to centre the first sample
//   rx_state_t       : receiver FSM states
// ----------------------------------------------------------------------------
package uart_pkg;

   localparam int unsigned BAUD_DIV_DEFAULT = 2604;

   typedef enum logic {
      IDLE,
      RECEIVE
   } rx_state_t;

   function automatic int unsigned half_bit(input int unsigned div);
      return div / 2;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// ----------------------------------------------------------------------------
// uart_rx_if -- serial-line and consumer-side signals of the UART receiver.
//   RX        : asynchronous serial input, idle high
//   clr_rdy   : one-cycle strobe from the consumer, clears rdy
//   rx_data   : last received byte
//   rdy       : sticky byte-available flag
//   frame_err : stop bit sampled low (only with UART_RX_FRAME_ERR_EN)
// Modports: slave = receiver side, master = line driver / consumer side.
// ----------------------------------------------------------------------------
interface uart_rx_if;

   logic       RX;
   logic       clr_rdy;
   logic [7:0] rx_data;
   logic       rdy;
`ifdef UART_RX_FRAME_ERR_EN
   logic       frame_err;
`endif

`ifdef UART_RX_FRAME_ERR_EN
   modport slave  (input RX, input clr_rdy, output rx_data, output rdy, output frame_err);
   modport master (output RX, output clr_rdy, input rx_data, input rdy, input frame_err);
`else
   modport slave  (input RX, input clr_rdy, output rx_data, output rdy);
   modport master (output RX, output clr_rdy, input rx_data, input rdy);
`endif

endinterface

// File: rtl/uart_rx_sync.sv
// ----------------------------------------------------------------------------
// uart_rx_sync -- three-flop synchronizer on the RX pin with falling-edge
// detect. All flops reset to 1 (idle line level).
//   clk, rst   : system clock, synchronous active-high reset
//   RX         : asynchronous serial input
//   rx_sync    : RX after two flops
//   start_edge : rx_prev = 1 and rx_sync = 0 (one cycle per falling edge)
// ----------------------------------------------------------------------------
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic RX,
   output logic rx_sync,
   output logic start_edge
);

   logic meta;
   logic rx_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta    <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         meta    <= RX;
         rx_sync <= meta;
         rx_prev <= rx_sync;
      end
   end

   assign start_edge = rx_prev & ~rx_sync;

endmodule

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx -- 8N1 serial receiver (LSB first, idle high, one start, one stop).
// The received byte is presented with a sticky rdy flag cleared by clr_rdy.
//   BAUD_DIV : clocks per bit, >= 4
//   clk, rst : system clock, synchronous active-high reset
//   bus      : uart_rx_if.slave (RX, clr_rdy, rx_data, rdy[, frame_err])
// Optional feature: define UART_RX_FRAME_ERR_EN to add frame_err, set when the
// stop bit samples low.
// ----------------------------------------------------------------------------
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
   input logic     clk,
   input logic     rst,
   uart_rx_if.slave bus
);

   localparam int unsigned CW = $clog2(BAUD_DIV);
   // The detection cycle is the first cycle of the half bit, so the counter
   // starts one lower; the first sample then falls exactly half_bit() cycles
   // after the first low rx_sync.
   localparam logic [CW-1:0] HALF_LOAD = CW'(half_bit(BAUD_DIV) - 1);
   localparam logic [CW-1:0] BIT_LOAD  = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   logic rx_sync;
   logic start_edge;

   uart_rx_sync u_sync (
      .clk        (clk),
      .rst        (rst),
      .RX         (bus.RX),
      .rx_sync    (rx_sync),
      .start_edge (start_edge)
   );

   rx_state_t     state, state_n;
   logic [CW-1:0] baud_cnt, baud_cnt_n;
   logic [3:0]    bit_cnt, bit_cnt_n;
   logic [8:0]    shreg, shreg_n;
   logic [7:0]    data_q, data_n;
   logic          rdy_q, rdy_n;
`ifdef UART_RX_FRAME_ERR_EN
   logic          ferr_q, ferr_n;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         data_q   <= '0;
         rdy_q    <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
         ferr_q   <= 1'b0;
`endif
      end else begin
         state    <= state_n;
         baud_cnt <= baud_cnt_n;
         bit_cnt  <= bit_cnt_n;
         shreg    <= shreg_n;
         data_q   <= data_n;
         rdy_q    <= rdy_n;
`ifdef UART_RX_FRAME_ERR_EN
         ferr_q   <= ferr_n;
`endif
      end
   end

   always_comb begin
      state_n    = state;
      baud_cnt_n = baud_cnt;
      bit_cnt_n  = bit_cnt;
      shreg_n    = shreg;
      data_n     = data_q;
      rdy_n      = rdy_q;
`ifdef UART_RX_FRAME_ERR_EN
      ferr_n     = ferr_q;
`endif

      // Lowest priority: consumer clear. Start detection and frame completion
      // below override it.
      if (bus.clr_rdy) begin
         rdy_n = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
         ferr_n = 1'b0;
`endif
      end

      unique case (state)
         IDLE: begin
            if (start_edge) begin
               baud_cnt_n = HALF_LOAD;
               bit_cnt_n  = '0;
               rdy_n      = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
               ferr_n     = 1'b0;
`endif
               state_n    = RECEIVE;
            end
         end
         RECEIVE: begin
            if (baud_cnt == '0) begin
               baud_cnt_n = BIT_LOAD;
               shreg_n    = {rx_sync, shreg[8:1]};
               bit_cnt_n  = bit_cnt + 4'd1;
               if (bit_cnt == 4'd0 && rx_sync) begin
                  // start bit high at mid-bit: glitch, abandon quietly
                  state_n = IDLE;
               end else if (bit_cnt == 4'd9) begin
                  state_n = IDLE;
                  data_n  = shreg_n[7:0];
                  rdy_n   = 1'b1;
`ifdef UART_RX_FRAME_ERR_EN
                  ferr_n  = ~rx_sync;
`endif
               end
            end else begin
               baud_cnt_n = baud_cnt - CNT_ONE;
            end
         end
      endcase
   end

   assign bus.rx_data = data_q;
   assign bus.rdy     = rdy_q;
`ifdef UART_RX_FRAME_ERR_EN
   assign bus.frame_err = ferr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx. Three receivers with
// BAUD_DIV 2604, 16 and 5 share clk/rst; a timestamp-based frame model per
// receiver predicts rdy/rx_data/frame_err every cycle, and directed checks pin
// key latencies and values. Honors UART_RX_FRAME_ERR_EN.
// ----------------------------------------------------------------------------
module tb_uart_rx;

   localparam int DIV [3] = '{2604, 16, 5};

   logic clk;
   logic rst;
   int   cyc;
   int   checks;
   int   errors;

   logic       pin    [3];
   logic       clr    [3];
   logic [7:0] d_data [3];
   logic       d_rdy  [3];
   logic       d_ferr [3];

   uart_rx_if ifa ();
   uart_rx_if ifb ();
   uart_rx_if ifc ();

   uart_rx #(.BAUD_DIV(2604)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
   uart_rx #(.BAUD_DIV(16))   dut_b (.clk(clk), .rst(rst), .bus(ifb));
   uart_rx #(.BAUD_DIV(5))    dut_c (.clk(clk), .rst(rst), .bus(ifc));

   assign ifa.RX = pin[0];
   assign ifb.RX = pin[1];
   assign ifc.RX = pin[2];
   assign ifa.clr_rdy = clr[0];
   assign ifb.clr_rdy = clr[1];
   assign ifc.clr_rdy = clr[2];
   assign d_data[0] = ifa.rx_data;
   assign d_data[1] = ifb.rx_data;
   assign d_data[2] = ifc.rx_data;
   assign d_rdy[0]  = ifa.rdy;
   assign d_rdy[1]  = ifb.rdy;
   assign d_rdy[2]  = ifc.rdy;
`ifdef UART_RX_FRAME_ERR_EN
   assign d_ferr[0] = ifa.frame_err;
   assign d_ferr[1] = ifb.frame_err;
   assign d_ferr[2] = ifc.frame_err;
`else
   assign d_ferr[0] = 1'b0;
   assign d_ferr[1] = 1'b0;
   assign d_ferr[2] = 1'b0;
`endif

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- model: timestamps straight from the frame timing rules
   bit         model_valid;
   bit         m_line [3][3];   // [i][0]=newest pin sample .. [i][2]=oldest
   bit         m_busy [3];
   int         m_start[3];
   int         m_k    [3];
   logic [9:0] m_bits [3];
   logic [7:0] m_data [3];
   bit         m_rdy  [3];
   bit         m_ferr [3];

   initial begin
      model_valid = 1'b0;
      cyc = 0;
      forever begin
         @(posedge clk);
         for (int i = 0; i < 3; i++) begin
            if (rst) begin
               for (int j = 0; j < 3; j++) m_line[i][j] = 1'b1;
               m_busy[i] = 1'b0;
               m_k[i]    = 0;
               m_data[i] = 8'h00;
               m_rdy[i]  = 1'b0;
               m_ferr[i] = 1'b0;
            end else begin
               bit sync, prev, det, set;
               sync = m_line[i][1];   // pin as it was two cycles ago
               prev = m_line[i][2];
               det = 1'b0;
               set = 1'b0;
               if (!m_busy[i]) begin
                  if (prev && !sync) begin
                     det = 1'b1;
                     m_busy[i]  = 1'b1;
                     m_start[i] = cyc;
                     m_k[i]     = 0;
                  end
               end else if (cyc == m_start[i] + DIV[i] / 2 + m_k[i] * DIV[i]) begin
                  m_bits[i][m_k[i]] = sync;
                  if (m_k[i] == 0 && sync) m_busy[i] = 1'b0;
                  else if (m_k[i] == 9) begin
                     m_busy[i] = 1'b0;
                     set = 1'b1;
                  end
                  m_k[i]++;
               end
               if (set) begin
                  m_data[i] = m_bits[i][8:1];
                  m_rdy[i]  = 1'b1;
                  m_ferr[i] = !m_bits[i][9];
               end else if (det || clr[i]) begin
                  m_rdy[i]  = 1'b0;
                  m_ferr[i] = 1'b0;
               end
               m_line[i][2] = m_line[i][1];
               m_line[i][1] = m_line[i][0];
               m_line[i][0] = pin[i];
            end
         end
         if (rst) model_valid = 1'b1;
         cyc++;
      end
   end

   // ---------------- per-cycle compare against the model
   initial begin
      forever begin
         @(negedge clk);
         if (model_valid) begin
            for (int i = 0; i < 3; i++) begin
               chk($sformatf("rdy[%0d]", i), 32'(d_rdy[i]), 32'(m_rdy[i]));
               chk($sformatf("rx_data[%0d]", i), 32'(d_data[i]), 32'(m_data[i]));
`ifdef UART_RX_FRAME_ERR_EN
               chk($sformatf("frame_err[%0d]", i), 32'(d_ferr[i]), 32'(m_ferr[i]));
`endif
            end
         end
      end
   end

   // ---------------- stimulus
   // Drives a frame starting in the current cycle; bit k occupies cycles
   // [k*D, (k+1)*D). clr_rdy is pulsed in frame-relative cycle clr_at.
   task automatic send(input int i, input logic [7:0] b, input logic stop,
                       input int len, input int clr_at);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      for (int t = 0; t < len; t++) begin
         pin[i] = fr[t / DIV[i]];
         clr[i] = (t == clr_at);
         @(negedge clk);
      end
      clr[i] = 1'b0;
   endtask

   task automatic wait_rdy(input int i, input int bound, output int at);
      at = -1;
      for (int t = 0; t < bound; t++) begin
         @(negedge clk);
         if (d_rdy[i]) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) chk($sformatf("rdy_timeout[%0d]", i), 32'd0, 32'd1);
   endtask

   task automatic pulse_clr(input int i);
      clr[i] = 1'b1;
      @(negedge clk);
      clr[i] = 1'b0;
   endtask

   initial begin
      int c0, at;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         pin[i] = 1'b1;
         clr[i] = 1'b0;
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("reset_rdy", 32'(d_rdy[i]), 32'd0);
         chk("reset_data", 32'(d_data[i]), 32'h00);
      end

      // 0xA5 at default divisor: rdy at S+24739, S = c0+2
      c0 = cyc;
      fork
         send(0, 8'hA5, 1'b1, 10 * 2604, -1);
         wait_rdy(0, 30000, at);
      join
      chk("a5_latency", 32'(at - c0), 32'd24741);
      chk("a5_data", 32'(d_data[0]), 32'hA5);
`ifdef UART_RX_FRAME_ERR_EN
      chk("a5_ferr", 32'(d_ferr[0]), 32'd0);
`endif

      // clear, then a 1000-cycle glitch (shorter than half a bit)
      pulse_clr(0);
      chk("clr_rdy", 32'(d_rdy[0]), 32'd0);
      pin[0] = 1'b0;
      repeat (1000) @(negedge clk);
      pin[0] = 1'b1;
      repeat (3000) @(negedge clk);
      chk("glitch_no_rdy", 32'(d_rdy[0]), 32'd0);
      chk("glitch_data_kept", 32'(d_data[0]), 32'hA5);
      fork
         send(0, 8'h3C, 1'b1, 10 * 2604, -1);
         wait_rdy(0, 30000, at);
      join
      chk("3c_data", 32'(d_data[0]), 32'h3C);

      // 0x00 with low stop bit, line then held low
      fork
         send(1, 8'h00, 1'b0, 160, -1);
         wait_rdy(1, 200, at);
      join
      chk("zero_data", 32'(d_data[1]), 32'h00);
`ifdef UART_RX_FRAME_ERR_EN
      chk("zero_ferr", 32'(d_ferr[1]), 32'd1);
`endif
      repeat (100) @(negedge clk);
      chk("held_low_rdy", 32'(d_rdy[1]), 32'd1);
      pin[1] = 1'b1;
      repeat (40) @(negedge clk);

      // back-to-back 0x12, 0x34; clr_rdy lands on the second completion
      // (frame cycle 2 + 8 + 9*16 = 154)
      send(1, 8'h12, 1'b1, 160, -1);
      send(1, 8'h34, 1'b1, 160, 154);
      chk("b2b_rdy", 32'(d_rdy[1]), 32'd1);
      chk("b2b_data", 32'(d_data[1]), 32'h34);

      // reset in the middle of bit 5, then a clean 0x7E
      send(1, 8'h55, 1'b1, 5 * 16 + 8, -1);
      rst = 1'b1;
      pin[1] = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_rdy", 32'(d_rdy[1]), 32'd0);
      chk("midrst_data", 32'(d_data[1]), 32'h00);
      repeat (20) @(negedge clk);
      fork
         send(1, 8'h7E, 1'b1, 160, -1);
         wait_rdy(1, 200, at);
      join
      chk("7e_data", 32'(d_data[1]), 32'h7E);

      // odd divisor 5: half bit 2, rdy at S+2+45+1, S = c0+2
      c0 = cyc;
      fork
         send(2, 8'h81, 1'b1, 50, -1);
         wait_rdy(2, 80, at);
      join
      chk("81_latency", 32'(at - c0), 32'd50);
      chk("81_data", 32'(d_data[2]), 32'h81);

      repeat (10) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
